axis_frame_join_mask: RTL and testbench

- Parametrised successor to the team's AXI4-Stream frame joiner.
- Concatenates one frame from each *enabled* input port, in ascending port order, into one output frame, optionally prefixed by a multi-word tag.
- Adds tkeep and multi-bit tuser, a per-frame port-enable mask, and abort on a per-port error.
- Sits between parallel producers (e.g. header/payload/trailer generators) and a single downstream packet sink.

---
 rtl/axis_frame_join_mask.sv | 243 ++++++++++++++++++++++++
 tb/tb_axis_frame_join_mask.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_join_mask.sv
// rtl/axis_frame_join_mask.sv - joins one frame per enabled input port behind an optional tag; AXIS_FRAME_JOIN_ABORT_EN adds abort/drain
module axis_frame_join_mask #(
    parameter int S_COUNT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int USER_WIDTH  = 1,
    parameter bit TAG_ENABLE  = 1,
    parameter int TAG_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [S_COUNT-1:0]           s_axis_tvalid,
    output logic [S_COUNT-1:0]           s_axis_tready,
    input  logic [S_COUNT-1:0]           s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]        m_axis_tkeep,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic [USER_WIDTH-1:0]        m_axis_tuser,
    input  logic [S_COUNT-1:0]           port_mask,
    input  logic [TAG_WIDTH-1:0]         tag,
    output logic                         busy,
    output logic                         abort
);

    localparam int SEL_W     = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;
    localparam int TAG_WORDS = (TAG_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int TCNT_W    = (TAG_WORDS > 1) ? $clog2(TAG_WORDS) : 1;
    localparam int TAG_PAD_W = TAG_WORDS * DATA_WIDTH;

`ifdef AXIS_FRAME_JOIN_ABORT_EN
    typedef enum logic [1:0] {IDLE, TAG, XFER, DRAIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, TAG, XFER} state_t;
`endif

    state_t                 state, state_next;
    logic [SEL_W-1:0]       sel, sel_next, next_sel, first_sel;
    logic [S_COUNT-1:0]     mask_reg, mask_next;
    logic [TAG_PAD_W-1:0]   tag_reg, tag_next;
    logic [TCNT_W-1:0]      tag_cnt, tcnt_next;
    logic [USER_WIDTH-1:0]  user_acc, acc_next;
    logic                   is_final;

    logic [DATA_WIDTH-1:0]  in_data;
    logic [KEEP_WIDTH-1:0]  in_keep;
    logic [USER_WIDTH-1:0]  in_user;
    logic                   in_valid, in_last;

    logic                   ready;
    logic                   push, push_last;
    logic [DATA_WIDTH-1:0]  push_data;
    logic [KEEP_WIDTH-1:0]  push_keep;
    logic [USER_WIDTH-1:0]  push_user;

    logic [DATA_WIDTH-1:0]  out_data, tmp_data;
    logic [KEEP_WIDTH-1:0]  out_keep, tmp_keep;
    logic [USER_WIDTH-1:0]  out_user, tmp_user;
    logic                   out_valid, out_last, tmp_valid, tmp_last;
    logic                   out_free;

    assign in_data  = s_axis_tdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
    assign in_keep  = KEEP_ENABLE ? s_axis_tkeep[int'(sel)*KEEP_WIDTH +: KEEP_WIDTH] : '1;
    assign in_user  = s_axis_tuser[int'(sel)*USER_WIDTH +: USER_WIDTH];
    assign in_valid = s_axis_tvalid[sel];
    assign in_last  = s_axis_tlast[sel];

    // Lowest set bit above sel in the latched mask; none left means this port closes the frame.
    always_comb begin
        next_sel = sel;
        is_final = 1'b1;
        for (int i = S_COUNT - 1; i >= 0; i--) begin
            if (i > int'(sel) && mask_reg[i]) begin
                next_sel = SEL_W'(i);
                is_final = 1'b0;
            end
        end
    end

    always_comb begin
        first_sel = '0;
        for (int i = S_COUNT - 1; i >= 0; i--) begin
            if (port_mask[i]) first_sel = SEL_W'(i);
        end
    end

    always_comb begin
        state_next = state;
        sel_next   = sel;
        mask_next  = mask_reg;
        tag_next   = tag_reg;
        tcnt_next  = tag_cnt;
        acc_next   = user_acc;
        ready      = 1'b0;
        push       = 1'b0;
        push_data  = '0;
        push_keep  = '1;
        push_last  = 1'b0;
        push_user  = '0;
        case (state)
            IDLE: begin
                if (port_mask != '0 && s_axis_tvalid[first_sel]) begin
                    mask_next  = port_mask;
                    tag_next   = TAG_PAD_W'(tag);
                    sel_next   = first_sel;
                    tcnt_next  = '0;
                    acc_next   = '0;
                    state_next = TAG_ENABLE ? TAG : XFER;
                end
            end
            TAG: begin
                if (!tmp_valid) begin
                    push      = 1'b1;
                    push_data = tag_reg[int'(tag_cnt)*DATA_WIDTH +: DATA_WIDTH];
                    if (tag_cnt == TCNT_W'(TAG_WORDS - 1)) state_next = XFER;
                    else                                    tcnt_next  = tag_cnt + 1'b1;
                end
            end
            XFER: begin
                ready = !tmp_valid;
                if (ready && in_valid) begin
                    push      = 1'b1;
                    push_data = in_data;
                    push_keep = in_keep;
                    acc_next  = user_acc | in_user;
                    if (in_last) begin
                        if (is_final) begin
                            push_last  = 1'b1;
                            push_user  = user_acc | in_user;
                            state_next = IDLE;
`ifdef AXIS_FRAME_JOIN_ABORT_EN
                        end else if (in_user[0]) begin
                            push_last  = 1'b1;
                            push_user  = user_acc | in_user;
                            sel_next   = next_sel;
                            state_next = DRAIN;
`endif
                        end else begin
                            sel_next = next_sel;
                        end
                    end
                end
            end
`ifdef AXIS_FRAME_JOIN_ABORT_EN
            DRAIN: begin
                // Remaining ports are swallowed without touching the output stage.
                ready = 1'b1;
                if (in_valid && in_last) begin
                    if (is_final) state_next = IDLE;
                    else          sel_next   = next_sel;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    assign s_axis_tready = (ready && rst_n) ? (S_COUNT'(1) << sel) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= '0;
            mask_reg <= '0;
            tag_reg  <= '0;
            tag_cnt  <= '0;
            user_acc <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            sel      <= sel_next;
            mask_reg <= mask_next;
            tag_reg  <= tag_next;
            tag_cnt  <= tcnt_next;
            user_acc <= acc_next;
            busy     <= (state_next != IDLE);
        end
    end

`ifdef AXIS_FRAME_JOIN_ABORT_EN
    logic abort_reg;
    always_ff @(posedge clk) begin
        if (!rst_n) abort_reg <= 1'b0;
        else        abort_reg <= (state == XFER) && (state_next == DRAIN);
    end
    assign abort = abort_reg;
`else
    assign abort = 1'b0;
`endif

    // Skid buffer: the temp register catches the one beat accepted while the output is stalled.
    assign out_free = !out_valid || m_axis_tready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            out_user  <= '0;
            tmp_valid <= 1'b0;
            tmp_data  <= '0;
            tmp_keep  <= '0;
            tmp_last  <= 1'b0;
            tmp_user  <= '0;
        end else if (out_free) begin
            if (tmp_valid) begin
                out_valid <= 1'b1;
                out_data  <= tmp_data;
                out_keep  <= tmp_keep;
                out_last  <= tmp_last;
                out_user  <= tmp_user;
                tmp_valid <= 1'b0;
            end else if (push) begin
                out_valid <= 1'b1;
                out_data  <= push_data;
                out_keep  <= push_keep;
                out_last  <= push_last;
                out_user  <= push_user;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (push) begin
            tmp_valid <= 1'b1;
            tmp_data  <= push_data;
            tmp_keep  <= push_keep;
            tmp_last  <= push_last;
            tmp_user  <= push_user;
        end
    end

    assign m_axis_tvalid = out_valid;
    assign m_axis_tdata  = out_data;
    assign m_axis_tkeep  = KEEP_ENABLE ? out_keep : '1;
    assign m_axis_tlast  = out_last;
    assign m_axis_tuser  = out_user;

endmodule

// File: tb/tb_axis_frame_join_mask.sv
// tb/tb_axis_frame_join_mask.sv - scoreboard bench for axis_frame_join_mask
module tb_axis_frame_join_mask;

    localparam int S  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [S*DW-1:0] s_tdata;
    logic [S-1:0]    s_tkeep, s_tvalid, s_tready, s_tlast, s_tuser;
    logic [DW-1:0]   m_tdata;
    logic            m_tkeep, m_tvalid, m_tready, m_tlast, m_tuser;
    logic [S-1:0]    port_mask;
    logic [15:0]     tag;
    logic            busy, abort;

    always #5 clk = ~clk;

    axis_frame_join_mask #(
        .S_COUNT(S), .DATA_WIDTH(DW), .KEEP_ENABLE(1), .KEEP_WIDTH(1),
        .USER_WIDTH(1), .TAG_ENABLE(1), .TAG_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .port_mask(port_mask), .tag(tag), .busy(busy), .abort(abort)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       k;
        logic       l;
        logic       u;
    } beat_t;

    beat_t       src_q[S][$];
    beat_t       exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          bad_ready = 0;
    int          abort_cnt = 0;
    logic [S-1:0] mask_chk = 4'hF;
    bit          mon_en = 1'b1;
    bit          toggle = 1'b0;

    task automatic add_src(int p, logic [7:0] d, logic k, logic l, logic u);
        src_q[p].push_back({d, k, l, u});
    endtask

    task automatic add_exp(logic [7:0] d, logic k, logic l, logic u);
        exp_q.push_back({d, k, l, u});
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_done(string name);
        bit done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            tick();
            if (exp_q.size() == 0 && !busy && !m_tvalid) done = 1'b1;
        end
        check({name, "_complete"}, 32'(done), 32'd1);
        tick();
    endtask

    task automatic clear_src();
        for (int p = 0; p < S; p++) src_q[p].delete();
    endtask

    // Source driver: sees handshakes at the falling edge, retires them after the rising edge.
    initial begin
        logic [S-1:0] fire;
        s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tuser = '0;
        m_tready = 1'b1;
        forever begin
            @(negedge clk);
            fire = s_tvalid & s_tready;
            @(posedge clk);
            #1;
            for (int p = 0; p < S; p++) begin
                if (fire[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
                if (src_q[p].size() > 0) begin
                    s_tvalid[p]          = 1'b1;
                    s_tdata[p*DW +: DW]  = src_q[p][0].d;
                    s_tkeep[p]           = src_q[p][0].k;
                    s_tlast[p]           = src_q[p][0].l;
                    s_tuser[p]           = src_q[p][0].u;
                end else begin
                    s_tvalid[p]          = 1'b0;
                    s_tdata[p*DW +: DW]  = '0;
                    s_tkeep[p]           = 1'b0;
                    s_tlast[p]           = 1'b0;
                    s_tuser[p]           = 1'b0;
                end
            end
            m_tready = toggle ? ~m_tready : 1'b1;
        end
    end

    // Output monitor and scoreboard.
    initial begin
        beat_t e, got;
        forever begin
            @(negedge clk);
            if (rst_n && (s_tready & ~mask_chk) != '0) bad_ready++;
            if (abort) abort_cnt++;
            if (mon_en && m_tvalid && m_tready) begin
                n_checks++;
                got = {m_tdata, m_tkeep, m_tlast, m_tuser};
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL out_unexpected: got d=%h k=%b l=%b u=%b with empty scoreboard",
                             m_tdata, m_tkeep, m_tlast, m_tuser);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e)begin
                        n_fail++;
                        $display("FAIL out_beat: got d=%h k=%b l=%b u=%b expected d=%h k=%b l=%b u=%b",
                                 got.d, got.k, got.l, got.u, e.d, e.k, e.l, e.u);
                    end
                end
            end
        end
    end

    initial begin
        bit seen;
        port_mask = '0;
        tag = '0;

        // Reset state
        repeat (3) tick();
        check("rst_m_tvalid", 32'(m_tvalid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_s_tready", 32'(s_tready), 0);
        check("rst_abort", 32'(abort), 0);
        rst_n = 1'b1;
        tick();

        // All four ports, tag CD/AB, keep=0 on port 0's last beat
        port_mask = 4'b1111; tag = 16'hABCD; mask_chk = 4'b1111;
        add_exp(8'hCD, 1, 0, 0); add_exp(8'hAB, 1, 0, 0);
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 3; k++) begin
                add_src(p, 8'(p + k), (p == 0 && k == 2) ? 1'b0 : 1'b1, k == 2, 1'b0);
                add_exp(8'(p + k), (p == 0 && k == 2) ? 1'b0 : 1'b1, (p == 3 && k == 2), 1'b0);
            end
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            if (m_tvalid) seen = 1'b1;
        end
        check("t1_first_out", 32'(seen), 1);
        check("t1_busy_mid", 32'(busy), 1);
        wait_done("t1");
        check("t1_busy_after", 32'(busy), 0);

        // Mask 1010: ports 0/2 hold a valid beat that must never be taken
        port_mask = 4'b1010; tag = 16'h1357; mask_chk = 4'b1010;
        add_src(0, 8'hEE, 1, 1, 0); add_src(2, 8'hEE, 1, 1, 0);
        add_src(1, 8'hA0, 1, 0, 0); add_src(1, 8'hA1, 1, 1, 0);
        add_src(3, 8'hB0, 1, 0, 0); add_src(3, 8'hB1, 1, 1, 0);
        add_exp(8'h57, 1, 0, 0); add_exp(8'h13, 1, 0, 0);
        add_exp(8'hA0, 1, 0, 0); add_exp(8'hA1, 1, 0, 0);
        add_exp(8'hB0, 1, 0, 0); add_exp(8'hB1, 1, 1, 0);
        wait_done("t2");
        check("t2_bad_ready", 32'(bad_ready), 0);
        check("t2_port0_untouched", 32'(src_q[0].size()), 1);
        check("t2_port2_untouched", 32'(src_q[2].size()), 1);
        clear_src();
        repeat (2) tick();
        mask_chk = 4'b1111;

        // 64-beat join under toggling back-pressure; mask change mid-frame ignored
        port_mask = 4'b1111; tag = 16'h0F1E; toggle = 1'b1;
        add_exp(8'h1E, 1, 0, 0); add_exp(8'h0F, 1, 0, 0);
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 16; k++) begin
                add_src(p, 8'(p * 16 + k), 1, k == 15, 0);
                add_exp(8'(p * 16 + k), 1, (p == 3 && k == 15), 0);
            end
        repeat (10) tick();
        port_mask = 4'b0001;
        wait_done("t3");
        toggle = 1'b0;
        repeat (2) tick();

        // Error on port 2's last beat
        port_mask = 4'b1111; tag = 16'h5A5A; abort_cnt = 0;
        add_exp(8'h5A, 1, 0, 0); add_exp(8'h5A, 1, 0, 0);
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 2; k++)
                add_src(p, 8'(8'h50 + p * 2 + k), 1, k == 1, (p == 2 && k == 1));
`ifdef AXIS_FRAME_JOIN_ABORT_EN
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < 2; k++)
                add_exp(8'(8'h50 + p * 2 + k), 1, (p == 2 && k == 1), (p == 2 && k == 1));
        wait_done("t4");
        check("t4_abort_pulses", 32'(abort_cnt), 1);
`else
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 2; k++)
                add_exp(8'(8'h50 + p * 2 + k), 1, (p == 3 && k == 1), (p == 3 && k == 1));
        wait_done("t4");
        check("t4_abort_pulses", 32'(abort_cnt), 0);
`endif
        check("t4_port3_consumed", 32'(src_q[3].size()), 0);

        // Reset in the middle of the payload, then a clean single-port frame
        port_mask = 4'b1111; tag = 16'h2468;
        add_exp(8'h68, 1, 0, 0); add_exp(8'h24, 1, 0, 0);
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 4; k++) begin
                add_src(p, 8'(8'h80 + p * 4 + k), 1, k == 3, 0);
                add_exp(8'(8'h80 + p * 4 + k), 1, (p == 3 && k == 3), 0);
            end
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (exp_q.size() <= 14) seen = 1'b1;
        end
        check("t5_reached_xfer", 32'(seen), 1);
        mon_en = 1'b0;
        rst_n = 1'b0;
        clear_src();
        tick();
        rst_n = 1'b1;
        check("t5_rst_m_tvalid", 32'(m_tvalid), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_s_tready", 32'(s_tready), 0);
        exp_q.delete();
        tick();
        mon_en = 1'b1;
        port_mask = 4'b0001; tag = 16'h1234;
        add_exp(8'h34, 1, 0, 0); add_exp(8'h12, 1, 0, 0);
        add_src(0, 8'hC0, 1, 0, 0); add_exp(8'hC0, 1, 0, 0);
        add_src(0, 8'hC1, 1, 0, 0); add_exp(8'hC1, 1, 0, 0);
        add_src(0, 8'hC2, 1, 1, 0); add_exp(8'hC2, 1, 1, 0);
        wait_done("t5");
        check("final_bad_ready", 32'(bad_ready), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
